hand_swing_detector: RTL and testbench
======================================

// Module: hand_swing_detector
// PURPOSE
// Consumer side of the hand-coordinate interface. Samples the top hand point
// (x,y) at a fixed rate and computes a per-sample delta that is aware of
// coordinate wrap-around. When motion exceeds a threshold, it emits a one-entry
// swing event (direction + speed) over a valid/ready handshake to game logic.
// The interface is identical whether coordinates come from the button test
// driver or from the camera tracker.
// PARAMETERS
// SAMPLE_PERIOD  1625000  clk cycles between coordinate samples (25 ms)
// MAX_X          3400     x coordinate modulus (range 0..MAX_X-1)
// MAX_Y          3400     y coordinate modulus (range 0..MAX_Y-1)
// SWING_THRESH   54       min |delta| per sample, dominant axis, to fire a swing
// COOLDOWN       8        samples ignored after an accepted swing (0 = none)
// PORTS
// clk_in         in   1   system clock
// rst_in         in   1   asynchronous, active-high reset
// hand_x_top     in   12  top hand point x, unsigned
// hand_y_top     in   12  top hand point y, unsigned
// swing_ready    in   1   consumer accepts the event
// swing_valid    out  1   event pending
// swing_dir      out  2   0=left(-x) 1=right(+x) 2=up(-y) 3=down(+y)
// swing_speed    out  12  |delta| on the dominant axis
// missed_count   out  8   saturating count of swings dropped while HOLD
// BEHAVIOUR
// - Reset (async): swing_valid=0, swing_dir=0, swing_speed=0, missed_count=0.
//   Sample counter=0, prev_x=prev_y=0, cooldown counter=0, state=PRIME.
// - Strobe: counter runs 0..SAMPLE_PERIOD-1 and wraps. Strobe fires when
//   counter==SAMPLE_PERIOD-1. Inputs are ignored on all non-strobe cycles.
// - Every strobe, in every state, loads prev_x/prev_y <= current inputs.
// - Delta: dx = cur - prev, 13-bit signed. If dx > MAX_X/2 then dx -= MAX_X;
//   if dx < -MAX_X/2 then dx += MAX_X. Same rule for y with MAX_Y.
//   |d| <= 1700 after correction, so it fits in 12 bits.
// - Dominant axis: x if |dx| >= |dy| (ties go to x), otherwise y.
//   Qualifies when the dominant |d| >= SWING_THRESH.
//   Direction: negative -> left/up; zero or positive -> right/down.
// - FSM:
//   PRIME: first strobe only loads prev; next state TRACK. No delta is evaluated.
//   TRACK: on a qualifying strobe, register dir/speed and go to HOLD.
//     swing_valid goes high the cycle after the strobe (latency 1).
//   HOLD: swing_valid=1. swing_dir and swing_speed stay stable until
//     swing_valid&&swing_ready. On a qualifying strobe without a handshake,
//     missed_count += 1 (saturates at 255); the held event is not replaced.
//     On the handshake cycle, swing_valid drops next cycle and cd <= COOLDOWN.
//     Next state is COOLDOWN, or TRACK if COOLDOWN==0.
//     Handshake and strobe in the same cycle: the handshake wins. prev updates,
//     no missed increment, and that strobe does not count toward cooldown.
//   COOLDOWN: each strobe decrements cd and its delta is discarded.
//     The strobe that takes cd from 1 to 0 moves to TRACK.
// - missed_count clears only on reset.
// - Reset mid-operation forces the reset values immediately, with no clock edge
//   needed. Any pending event is lost.
// TESTING (SAMPLE_PERIOD=16 for sim; other params default)
// 1. Reset, hold x=y=1800 for 4 strobes -> swing_valid stays 0 throughout.
// 2. x 1800->1872 between strobes, ready=1 -> valid 1 cycle after strobe,
//    dir=1, speed=72; valid=0 the cycle after the handshake.
// 3. Wrap: x 18->3350 (raw +3332, corrected -68) -> dir=0, speed=68.
//    Also x 3390->10 (corrected +20) -> no swing.
// 4. Tie dx=+60, dy=-60 -> dir=1, speed=60.
//    dx=+10, dy=+90 -> dir=3, speed=90.
// 5. ready=0 during 3 qualifying strobes -> first event held, missed_count=2.
//    Raise ready -> handshake; next 8 qualifying strobes give no valid.
//    The 9th fires an event.
// 6. Assert rst_in mid-HOLD between clock edges -> valid=0 at once, missed=0.
//    After release, the first strobe (even with a +100 jump) only primes and
//    gives no valid.

Source files
------------

// File: rtl/hand_swing_detector.sv
// Samples the top hand point at a fixed rate, computes wrap-aware deltas and emits
// one-entry swing events (direction + speed) over a valid/ready handshake.
module hand_swing_detector #(
  parameter int unsigned SAMPLE_PERIOD = 1625000,
  parameter int unsigned MAX_X         = 3400,
  parameter int unsigned MAX_Y         = 3400,
  parameter int unsigned SWING_THRESH  = 54,
  parameter int unsigned COOLDOWN      = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [11:0] hand_x_top,
  input  logic [11:0] hand_y_top,
  input  logic        swing_ready,
  output logic        swing_valid,
  output logic [1:0]  swing_dir,
  output logic [11:0] swing_speed,
  output logic [7:0]  missed_count
);

  localparam int unsigned CntW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int unsigned CdW  = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

  typedef enum logic [1:0] {StPrime, StTrack, StHold, StCool} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [11:0]      prev_x_q, prev_x_d, prev_y_q, prev_y_d;
  logic [CdW-1:0]   cd_q, cd_d;
  logic [1:0]       dir_q, dir_d;
  logic [11:0]      speed_q, speed_d;
  logic [7:0]       missed_q, missed_d;

  logic               strobe;
  logic signed [13:0] dx, dy;
  logic [11:0]        ax, ay, dom_abs;
  logic [1:0]         dom_dir;
  logic               x_dom, qualify;

  // Shortest signed step on a circular axis of the given modulus.
  function automatic logic signed [13:0] wrap_delta(input logic [11:0] cur,
                                                    input logic [11:0] prev,
                                                    input int unsigned modulus);
    logic signed [13:0] d, half, m;
    m    = $signed(14'(modulus));
    half = $signed(14'(modulus / 2));
    d    = $signed({2'b00, cur}) - $signed({2'b00, prev});
    if (d > half) begin
      d = d - m;
    end else if (d < -half) begin
      d = d + m;
    end
    return d;
  endfunction

  function automatic logic [11:0] abs12(input logic signed [13:0] d);
    logic signed [13:0] a;
    a = (d < 0) ? -d : d;
    return a[11:0];
  endfunction

  assign strobe  = (cnt_q == CntW'(SAMPLE_PERIOD - 1));
  assign dx      = wrap_delta(hand_x_top, prev_x_q, MAX_X);
  assign dy      = wrap_delta(hand_y_top, prev_y_q, MAX_Y);
  assign ax      = abs12(dx);
  assign ay      = abs12(dy);
  assign x_dom   = (ax >= ay);
  assign dom_abs = x_dom ? ax : ay;
  assign qualify = (dom_abs >= 12'(SWING_THRESH));
  assign dom_dir = x_dom ? ((dx < 0) ? 2'd0 : 2'd1) : ((dy < 0) ? 2'd2 : 2'd3);

  always_comb begin
    state_d  = state_q;
    cnt_d    = strobe ? '0 : cnt_q + 1'b1;
    prev_x_d = strobe ? hand_x_top : prev_x_q;
    prev_y_d = strobe ? hand_y_top : prev_y_q;
    cd_d     = cd_q;
    dir_d    = dir_q;
    speed_d  = speed_q;
    missed_d = missed_q;
    unique case (state_q)
      StPrime: begin
        if (strobe) state_d = StTrack;
      end
      StTrack: begin
        if (strobe && qualify) begin
          state_d = StHold;
          dir_d   = dom_dir;
          speed_d = dom_abs;
        end
      end
      StHold: begin
        // A handshake takes priority over a coincident strobe.
        if (swing_ready) begin
          cd_d    = CdW'(COOLDOWN);
          state_d = (COOLDOWN == 0) ? StTrack : StCool;
        end else if (strobe && qualify && (missed_q != 8'hFF)) begin
          missed_d = missed_q + 8'd1;
        end
      end
      StCool: begin
        if (strobe) begin
          cd_d = cd_q - 1'b1;
          if (cd_q == CdW'(1)) state_d = StTrack;
        end
      end
      default: state_d = StPrime;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q  <= StPrime;
      cnt_q    <= '0;
      prev_x_q <= '0;
      prev_y_q <= '0;
      cd_q     <= '0;
      dir_q    <= '0;
      speed_q  <= '0;
      missed_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prev_x_q <= prev_x_d;
      prev_y_q <= prev_y_d;
      cd_q     <= cd_d;
      dir_q    <= dir_d;
      speed_q  <= speed_d;
      missed_q <= missed_d;
    end
  end

  assign swing_valid  = (state_q == StHold);
  assign swing_dir    = dir_q;
  assign swing_speed  = speed_q;
  assign missed_count = missed_q;

endmodule

// File: tb/tb_hand_swing_detector.sv
// Scoreboarded bench for hand_swing_detector with a 16-cycle sample period.
module tb_hand_swing_detector;

  localparam int Period = 16;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [11:0] hand_x_top;
  logic [11:0] hand_y_top;
  logic        swing_ready;
  logic        swing_valid;
  logic [1:0]  swing_dir;
  logic [11:0] swing_speed;
  logic [7:0]  missed_count;

  int checks = 0;
  int errors = 0;
  int phase  = 0;
  logic [13:0] exp_q[$];
  logic [13:0] exp_ev;

  // {x0, y0, x1, y1, fires, dir, speed}
  int tbl [9][7] = '{
    '{1800, 1800, 1872, 1800, 1, 1,  72},
    '{  18, 1800, 3350, 1800, 1, 0,  68},
    '{3390, 1800,   10, 1800, 0, 0,   0},
    '{1800, 1800, 1860, 1740, 1, 1,  60},
    '{1800, 1800, 1810, 1890, 1, 3,  90},
    '{1800, 1800, 1800, 1700, 1, 2, 100},
    '{1000, 1000, 1053, 1000, 0, 0,   0},
    '{1000, 1000, 1054, 1000, 1, 1,  54},
    '{1000,   10, 1000, 3300, 1, 2, 110}
  };

  hand_swing_detector #(
    .SAMPLE_PERIOD(Period)
  ) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .hand_x_top  (hand_x_top),
    .hand_y_top  (hand_y_top),
    .swing_ready (swing_ready),
    .swing_valid (swing_valid),
    .swing_dir   (swing_dir),
    .swing_speed (swing_speed),
    .missed_count(missed_count)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
    phase = (phase + 1) % Period;
  endtask

  // Leaves the bench 1 time unit after the next strobe edge.
  task automatic strobe(input logic [11:0] x, input logic [11:0] y);
    hand_x_top = x;
    hand_y_top = y;
    while (phase != Period - 1) tick();
    tick();
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    #2;
    rst_in = 1'b0;
    phase  = 0;
  endtask

  task automatic restart(input logic [11:0] x, input logic [11:0] y);
    do_reset();
    strobe(x, y);
  endtask

  task automatic test_reset();
    rst_in      = 1'b1;
    swing_ready = 1'b0;
    hand_x_top  = 12'd1800;
    hand_y_top  = 12'd1800;
    #2;
    checks++;
    if (swing_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid got %0d expected 0", swing_valid);
    end
    checks++;
    if (swing_dir !== 2'd0) begin
      errors++; $display("FAIL reset_dir got %0d expected 0", swing_dir);
    end
    checks++;
    if (swing_speed !== 12'd0) begin
      errors++; $display("FAIL reset_speed got %0d expected 0", swing_speed);
    end
    checks++;
    if (missed_count !== 8'd0) begin
      errors++; $display("FAIL reset_missed got %0d expected 0", missed_count);
    end
    rst_in = 1'b0;
    phase  = 0;
    for (int i = 0; i < 4; i++) begin
      repeat (Period / 2) tick();
      checks++;
      if (swing_valid !== 1'b0) begin
        errors++; $display("FAIL still_mid%0d got %0d expected 0", i, swing_valid);
      end
      strobe(12'd1800, 12'd1800);
      checks++;
      if (swing_valid !== 1'b0) begin
        errors++; $display("FAIL still_strobe%0d got %0d expected 0", i, swing_valid);
      end
    end
  endtask

  task automatic test_handshake();
    restart(12'd1800, 12'd1800);
    swing_ready = 1'b1;
    hand_x_top  = 12'd1872;
    while (phase != Period - 1) tick();
    checks++;
    if (swing_valid !== 1'b0) begin
      errors++; $display("FAIL hs_pre got %0d expected 0", swing_valid);
    end
    exp_q.push_back({2'd1, 12'd72});
    tick();
    checks++;
    if (swing_valid !== 1'b1) begin
      errors++; $display("FAIL hs_latency got %0d expected 1", swing_valid);
    end
    exp_ev = exp_q.pop_front();
    checks++;
    if ({swing_dir, swing_speed} !== exp_ev) begin
      errors++;
      $display("FAIL hs_event got dir %0d speed %0d expected dir %0d speed %0d",
               swing_dir, swing_speed, exp_ev[13:12], exp_ev[11:0]);
    end
    tick();
    checks++;
    if (swing_valid !== 1'b0) begin
      errors++; $display("FAIL hs_drop got %0d expected 0", swing_valid);
    end
  endtask

  task automatic test_direction();
    swing_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      restart(12'(tbl[i][0]), 12'(tbl[i][1]));
      if (tbl[i][4] != 0) exp_q.push_back({2'(tbl[i][5]), 12'(tbl[i][6])});
      strobe(12'(tbl[i][2]), 12'(tbl[i][3]));
      checks++;
      if (swing_valid !== 1'(tbl[i][4])) begin
        errors++; $display("FAIL dir%0d_valid got %0d expected %0d", i, swing_valid, tbl[i][4]);
      end
      if (exp_q.size() > 0) begin
        exp_ev = exp_q.pop_front();
        checks++;
        if ({swing_dir, swing_speed} !== exp_ev) begin
          errors++;
          $display("FAIL dir%0d_event got dir %0d speed %0d expected dir %0d speed %0d",
                   i, swing_dir, swing_speed, exp_ev[13:12], exp_ev[11:0]);
        end
      end
    end
  endtask

  task automatic test_hold_cooldown();
    restart(12'd1000, 12'd1000);
    swing_ready = 1'b0;
    exp_q.push_back({2'd1, 12'd100});
    for (int k = 0; k < 3; k++) begin
      strobe(12'(1100 + 100 * k), 12'd1000);
      checks++;
      if (swing_valid !== 1'b1) begin
        errors++; $display("FAIL hold%0d_valid got %0d expected 1", k, swing_valid);
      end
      checks++;
      if (missed_count !== 8'(k)) begin
        errors++; $display("FAIL hold%0d_missed got %0d expected %0d", k, missed_count, k);
      end
    end
    exp_ev = exp_q.pop_front();
    checks++;
    if ({swing_dir, swing_speed} !== exp_ev) begin
      errors++;
      $display("FAIL hold_event got dir %0d speed %0d expected dir %0d speed %0d",
               swing_dir, swing_speed, exp_ev[13:12], exp_ev[11:0]);
    end
    swing_ready = 1'b1;
    tick();
    checks++;
    if (swing_valid !== 1'b0) begin
      errors++; $display("FAIL hold_release got %0d expected 0", swing_valid);
    end
    for (int k = 0; k < 8; k++) begin
      strobe(12'(1400 + 100 * k), 12'd1000);
      checks++;
      if (swing_valid !== 1'b0) begin
        errors++; $display("FAIL cool%0d got %0d expected 0", k, swing_valid);
      end
    end
    exp_q.push_back({2'd1, 12'd100});
    strobe(12'd2200, 12'd1000);
    checks++;
    if (swing_valid !== 1'b1) begin
      errors++; $display("FAIL cool_end_valid got %0d expected 1", swing_valid);
    end
    exp_ev = exp_q.pop_front();
    checks++;
    if ({swing_dir, swing_speed} !== exp_ev) begin
      errors++;
      $display("FAIL cool_end_event got dir %0d speed %0d expected dir %0d speed %0d",
               swing_dir, swing_speed, exp_ev[13:12], exp_ev[11:0]);
    end
    checks++;
    if (missed_count !== 8'd2) begin
      errors++; $display("FAIL cool_missed got %0d expected 2", missed_count);
    end
  endtask

  task automatic test_reset_mid();
    restart(12'd1000, 12'd1000);
    swing_ready = 1'b0;
    strobe(12'd1100, 12'd1000);
    strobe(12'd1200, 12'd1000);
    checks++;
    if ((swing_valid !== 1'b1) || (missed_count !== 8'd1)) begin
      errors++;
      $display("FAIL mid_pre got valid %0d missed %0d expected valid 1 missed 1",
               swing_valid, missed_count);
    end
    rst_in = 1'b1;
    #1;
    checks++;
    if (swing_valid !== 1'b0) begin
      errors++; $display("FAIL mid_rst_valid got %0d expected 0", swing_valid);
    end
    checks++;
    if (missed_count !== 8'd0) begin
      errors++; $display("FAIL mid_rst_missed got %0d expected 0", missed_count);
    end
    #1;
    rst_in = 1'b0;
    phase  = 0;
    strobe(12'd1300, 12'd1000);
    checks++;
    if (swing_valid !== 1'b0) begin
      errors++; $display("FAIL mid_prime got %0d expected 0", swing_valid);
    end
    exp_q.push_back({2'd1, 12'd100});
    strobe(12'd1400, 12'd1000);
    checks++;
    if (swing_valid !== 1'b1) begin
      errors++; $display("FAIL mid_track got %0d expected 1", swing_valid);
    end
    exp_ev = exp_q.pop_front();
    checks++;
    if ({swing_dir, swing_speed} !== exp_ev) begin
      errors++;
      $display("FAIL mid_event got dir %0d speed %0d expected dir %0d speed %0d",
               swing_dir, swing_speed, exp_ev[13:12], exp_ev[11:0]);
    end
  endtask

  initial begin
    test_reset();
    test_handshake();
    test_direction();
    test_hold_cooldown();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
